// File: rtl/audio_pkg.sv
// Shared definitions for the audio frame capture block: default geometry,
// capture state encoding and the signed sample type.
package audio_pkg;

  localparam int N_DEFAULT = 100;
  localparam int W_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FULL    = 2'd2
  } cap_state_e;

  typedef logic signed [W_DEFAULT-1:0] sample_t;

endpackage

// File: rtl/audio_sample_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// Out-of-range reads return zero; a same-index read/write returns old data.
module audio_sample_ram #(
  parameter int N  = 100,
  parameter int W  = 32,
  parameter int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [N];
  logic [W-1:0] rdata_d, rdata_q;

  // Storage is deliberately left out of reset so frames survive it.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = '0;
    if (int'(raddr) < N) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/audio_frame_capture.sv
// Captures one N-sample frame on arm, holds it until released.
// Optional idle drop counter enabled by AUDIO_CAPTURE_DROP_CNT_EN.
module audio_frame_capture
  import audio_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int W = W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   arm,
  input  logic                   release_req,  // "release" is a reserved word
  input  logic                   in_valid,
  input  logic [W-1:0]           in_data,
  output logic                   in_ready,
  input  logic [$clog2(N)-1:0]   rd_addr,
  output logic [W-1:0]           rd_data,
  output logic                   frame_done,
  output logic                   full,
  output logic [$clog2(N+1)-1:0] count,
  output logic [15:0]            drop_count
);

  localparam int AW = $clog2(N);
  localparam int CW = $clog2(N+1);

  cap_state_e    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          frame_done_q, frame_done_d;
  logic          accept, wr_en;

  assign in_ready = (state_q != ST_FULL);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    full_d       = full_q;
    frame_done_d = 1'b0;
    wr_en        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d = ST_CAPTURE;
          count_d = '0;
        end
      end
      ST_CAPTURE: begin
        if (accept) begin
          wr_en   = 1'b1;
          count_d = count_q + 1'b1;
          if (count_q == CW'(N-1)) begin
            state_d      = ST_FULL;
            full_d       = 1'b1;
            frame_done_d = 1'b1;
          end
        end
      end
      ST_FULL: begin
        // Release together with arm starts the next frame without an idle gap.
        if (release_req) begin
          full_d  = 1'b0;
          state_d = arm ? ST_CAPTURE : ST_IDLE;
          if (arm) count_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      full_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      full_q       <= full_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign count      = count_q;
  assign full       = full_q;
  assign frame_done = frame_done_q;

  audio_sample_ram #(.N(N), .W(W)) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_en),
    .waddr (count_q[AW-1:0]),
    .wdata (in_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

`ifdef AUDIO_CAPTURE_DROP_CNT_EN
  logic [15:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (state_q == ST_IDLE && accept && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) drop_q <= 16'd0;
    else       drop_q <= drop_d;
  end

  assign drop_count = drop_q;
`else
  assign drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_audio_frame_capture.sv
// Directed bench for audio_frame_capture with a cycle-level reference model.
module tb_audio_frame_capture;

  localparam int N = 100;
  localparam int W = 32;

  logic        clk = 1'b0;
  logic        reset, arm, release_req, in_valid;
  logic [31:0] in_data;
  logic [6:0]  rd_addr;
  logic        in_ready, frame_done, full;
  logic [31:0] rd_data;
  logic [6:0]  count;
  logic [15:0] drop_count;

  int n_pass = 0;
  int n_tot  = 0;
  int done_seen = 0;

  // reference model state
  logic [31:0] mbuf   [N];
  bit          mknown [N];
  bit          mcap, mfull, mdone, mrd_known;
  int          mcount;
  int          mdrop;
  logic [31:0] mrd;

  audio_frame_capture #(.N(N), .W(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .arm         (arm),
    .release_req (release_req),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_done  (frame_done),
    .full        (full),
    .count       (count),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Abstract frame-capture rules applied to the inputs seen at a rising edge.
  task automatic model_update();
    if (reset) begin
      mcap = 0; mfull = 0; mdone = 0; mcount = 0; mdrop = 0;
      mrd = '0; mrd_known = 1;
    end else begin
      if (int'(rd_addr) < N) begin
        mrd = mbuf[rd_addr]; mrd_known = mknown[rd_addr];
      end else begin
        mrd = '0; mrd_known = 1;
      end
      mdone = 0;
      if (mfull) begin
        if (release_req) begin
          mfull = 0;
          if (arm) begin mcap = 1; mcount = 0; end
        end
      end else if (mcap) begin
        if (in_valid) begin
          mbuf[mcount] = in_data; mknown[mcount] = 1;
          mcount++;
          if (mcount == N) begin mcap = 0; mfull = 1; mdone = 1; end
        end
      end else begin
`ifdef AUDIO_CAPTURE_DROP_CNT_EN
        if (in_valid && mdrop < 65535) mdrop++;
`endif
        if (arm) begin mcap = 1; mcount = 0; end
      end
    end
  endtask

  task automatic compare();
    check("in_ready", {31'b0, in_ready}, {31'b0, !mfull});
    check("full", {31'b0, full}, {31'b0, mfull});
    check("frame_done", {31'b0, frame_done}, {31'b0, mdone});
    check("count", {25'b0, count}, 32'(mcount));
    check("drop_count", {16'b0, drop_count}, 32'(mdrop));
    if (mrd_known) check("rd_data", rd_data, mrd);
    if (frame_done === 1'b1) done_seen++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic feed(input int n, input int base, input int step);
    in_valid = 1;
    for (int i = 0; i < n; i++) begin
      in_data = 32'(base + step * i);
      tick();
    end
    in_valid = 0;
  endtask

  task automatic read_at(input int a, input string name, input logic [31:0] exp);
    rd_addr = 7'(a);
    tick();
    check(name, rd_data, exp);
  endtask

  initial begin
    int snap;
    reset = 1; arm = 0; release_req = 0; in_valid = 0; in_data = '0; rd_addr = '0;
    for (int i = 0; i < N; i++) mknown[i] = 0;
    mcap = 0; mfull = 0; mdone = 0; mcount = 0; mdrop = 0; mrd = '0; mrd_known = 0;
    repeat (3) tick();
    reset = 0;
    check("rst_count", {25'b0, count}, 32'd0);
    check("rst_full", {31'b0, full}, 32'd0);
    check("rst_frame_done", {31'b0, frame_done}, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_drop", {16'b0, drop_count}, 32'd0);

    // basic capture: samples i-50
    done_seen = 0;
    arm = 1; tick(); arm = 0;
    feed(N, -50, 1);
    check("basic_done", {31'b0, frame_done}, 32'd1);
    check("basic_full", {31'b0, full}, 32'd1);
    check("basic_count", {25'b0, count}, 32'd100);
    tick();
    check("basic_done_drop", {31'b0, frame_done}, 32'd0);
    check("basic_pulses", 32'(done_seen), 32'd1);
    read_at(0, "basic_addr0", 32'hFFFFFFCE);
    read_at(99, "basic_addr99", 32'd49);

    // backpressure in FULL, then idle drops
    in_data = 32'd123; in_valid = 1;
    repeat (10) tick();
    check("bp_ready", {31'b0, in_ready}, 32'd0);
    in_valid = 0;
    read_at(5, "bp_addr5", 32'hFFFFFFD3);
    release_req = 1; tick(); release_req = 0;
    feed(5, 7, 0);
    tick();
`ifdef AUDIO_CAPTURE_DROP_CNT_EN
    check("idle_drop5", {16'b0, drop_count}, 32'd5);
`else
    check("idle_drop5", {16'b0, drop_count}, 32'd0);
`endif

    // second frame 1000+i, with a same-cycle read/write at index 3
    arm = 1; tick(); arm = 0;
    in_valid = 1;
    for (int i = 0; i < N; i++) begin
      in_data = 32'(1000 + i);
      if (i == 3) rd_addr = 7'd3;
      tick();
      if (i == 3) check("rw_collision_old", rd_data, 32'hFFFFFFD1);
    end
    in_valid = 0;
    read_at(3, "frame2_addr3", 32'd1003);

    // release and arm together
    release_req = 1; arm = 1; tick(); release_req = 0; arm = 0;
    check("relarm_count", {25'b0, count}, 32'd0);
    check("relarm_ready", {31'b0, in_ready}, 32'd1);
    check("relarm_full", {31'b0, full}, 32'd0);
    in_valid = 1;
    in_data = 32'h7FFFFFFF; tick();
    in_data = 32'h80000000; tick();
    in_valid = 0;
    read_at(0, "max_pos", 32'h7FFFFFFF);
    read_at(1, "max_neg", 32'h80000000);
    read_at(100, "oob_read", 32'd0);

    // reset mid-capture after 40 samples
    feed(38, 5, 1);
    check("pre_rst_count", {25'b0, count}, 32'd40);
    snap = done_seen;
    reset = 1; tick(); reset = 0;
    check("midrst_count", {25'b0, count}, 32'd0);
    check("midrst_full", {31'b0, full}, 32'd0);
    repeat (3) tick();
    check("midrst_no_done", 32'(done_seen), 32'(snap));
    arm = 1; tick(); arm = 0;
    feed(N, 0, -1);
    check("refr_done", {31'b0, frame_done}, 32'd1);
    check("refr_pulses", 32'(done_seen), 32'(snap + 1));
    read_at(50, "refr_addr50", 32'hFFFFFFCE);

    // drop counter saturation
    release_req = 1; tick(); release_req = 0;
    feed(70000, 1, 0);
    tick();
`ifdef AUDIO_CAPTURE_DROP_CNT_EN
    check("drop_sat", {16'b0, drop_count}, 32'h0000FFFF);
`else
    check("drop_sat", {16'b0, drop_count}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
